// File: rtl/eth_stats_accumulator.sv
// rtl/eth_stats_accumulator.sv - TX/RX frame report accumulator with round-robin shared adder and snapshot readout
// Optional feature macro: ETH_STATS_SNAPSHOT_EN (snapshot registers and clear-on-snapshot).
module eth_stats_accumulator #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             tx_valid,
  input  logic [15:0]      tx_bytes,
  input  logic             tx_good,
  input  logic             rx_valid,
  input  logic [15:0]      rx_bytes,
  input  logic             rx_good,
  input  logic             snap_req,
  input  logic             snap_clear,
  output logic             snap_done,
  output logic [CNT_W-1:0] snap_tx_bytes,
  output logic [CNT_W-1:0] snap_tx_good,
  output logic [CNT_W-1:0] snap_tx_bad,
  output logic [CNT_W-1:0] snap_rx_bytes,
  output logic [CNT_W-1:0] snap_rx_good,
  output logic [CNT_W-1:0] snap_rx_bad,
  output logic [15:0]      dropped
);

  typedef enum logic {SRC_TX = 1'b0, SRC_RX = 1'b1} src_e;

  logic             tx_full_q, tx_full_d, rx_full_q, rx_full_d;
  logic [15:0]      tx_len_q, tx_len_d, rx_len_q, rx_len_d;
  logic             tx_ok_q, tx_ok_d, rx_ok_q, rx_ok_d;
  src_e             last_q, last_d;
  logic [15:0]      dropped_q, dropped_d;
  logic             snap_done_q;
  logic [CNT_W-1:0] txb_q, txg_q, txe_q, rxb_q, rxg_q, rxe_q;
  logic [CNT_W-1:0] txb_d, txg_d, txe_d, rxb_d, rxg_d, rxe_d;
  logic [CNT_W-1:0] txb_b, txg_b, txe_b, rxb_b, rxg_b, rxe_b;
  logic [CNT_W-1:0] byte_sum, inc_base, inc_res;
  logic [15:0]      upd_len;
  logic             upd_ok;
  logic             grant_tx, grant_rx, clear_live;
  logic             tx_acc, rx_acc, tx_drop, rx_drop;
  logic [16:0]      drop_sum;

  assign grant_tx = tx_full_q && (!rx_full_q || last_q == SRC_RX);
  assign grant_rx = rx_full_q && !grant_tx;

`ifdef ETH_STATS_SNAPSHOT_EN
  assign clear_live = snap_req && snap_clear;
`else
  assign clear_live = 1'b0;
`endif

  // A clear zeroes the base first, so an update granted in the same cycle lands on zero.
  assign txb_b = clear_live ? '0 : txb_q;
  assign txg_b = clear_live ? '0 : txg_q;
  assign txe_b = clear_live ? '0 : txe_q;
  assign rxb_b = clear_live ? '0 : rxb_q;
  assign rxg_b = clear_live ? '0 : rxg_q;
  assign rxe_b = clear_live ? '0 : rxe_q;

  assign upd_len  = grant_tx ? tx_len_q : rx_len_q;
  assign upd_ok   = grant_tx ? tx_ok_q : rx_ok_q;
  assign byte_sum = (grant_tx ? txb_b : rxb_b) + {{(CNT_W-16){1'b0}}, upd_len};
  assign inc_base = grant_tx ? (upd_ok ? txg_b : txe_b) : (upd_ok ? rxg_b : rxe_b);
  assign inc_res  = inc_base + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    txb_d = txb_b;
    txg_d = txg_b;
    txe_d = txe_b;
    rxb_d = rxb_b;
    rxg_d = rxg_b;
    rxe_d = rxe_b;
    if (grant_tx) begin
      txb_d = byte_sum;
      if (upd_ok) txg_d = inc_res;
      else        txe_d = inc_res;
    end else if (grant_rx) begin
      rxb_d = byte_sum;
      if (upd_ok) rxg_d = inc_res;
      else        rxe_d = inc_res;
    end
  end

  // The granted slot frees on this edge, so a report arriving now refills it instead of dropping.
  assign tx_acc  = enable && tx_valid;
  assign rx_acc  = enable && rx_valid;
  assign tx_drop = tx_acc && tx_full_q && !grant_tx;
  assign rx_drop = rx_acc && rx_full_q && !grant_rx;
  assign drop_sum = {1'b0, dropped_q} + {16'b0, tx_drop} + {16'b0, rx_drop};

  always_comb begin
    tx_full_d = tx_full_q && !grant_tx;
    tx_len_d  = tx_len_q;
    tx_ok_d   = tx_ok_q;
    rx_full_d = rx_full_q && !grant_rx;
    rx_len_d  = rx_len_q;
    rx_ok_d   = rx_ok_q;
    last_d    = last_q;
    if (tx_acc && !tx_drop) begin
      tx_full_d = 1'b1;
      tx_len_d  = tx_bytes;
      tx_ok_d   = tx_good;
    end
    if (rx_acc && !rx_drop) begin
      rx_full_d = 1'b1;
      rx_len_d  = rx_bytes;
      rx_ok_d   = rx_good;
    end
    if (grant_tx)      last_d = SRC_TX;
    else if (grant_rx) last_d = SRC_RX;
    dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_full_q   <= 1'b0;
      tx_len_q    <= '0;
      tx_ok_q     <= 1'b0;
      rx_full_q   <= 1'b0;
      rx_len_q    <= '0;
      rx_ok_q     <= 1'b0;
      last_q      <= SRC_RX;
      dropped_q   <= '0;
      snap_done_q <= 1'b0;
      txb_q       <= '0;
      txg_q       <= '0;
      txe_q       <= '0;
      rxb_q       <= '0;
      rxg_q       <= '0;
      rxe_q       <= '0;
    end else begin
      tx_full_q   <= tx_full_d;
      tx_len_q    <= tx_len_d;
      tx_ok_q     <= tx_ok_d;
      rx_full_q   <= rx_full_d;
      rx_len_q    <= rx_len_d;
      rx_ok_q     <= rx_ok_d;
      last_q      <= last_d;
      dropped_q   <= dropped_d;
      snap_done_q <= snap_req;
      txb_q       <= txb_d;
      txg_q       <= txg_d;
      txe_q       <= txe_d;
      rxb_q       <= rxb_d;
      rxg_q       <= rxg_d;
      rxe_q       <= rxe_d;
    end
  end

  assign snap_done = snap_done_q;
  assign dropped   = dropped_q;

`ifdef ETH_STATS_SNAPSHOT_EN
  logic [CNT_W-1:0] s_txb_q, s_txg_q, s_txe_q, s_rxb_q, s_rxg_q, s_rxe_q;

  // Snapshot captures pre-update values so the result is coherent across all six counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_txb_q <= '0;
      s_txg_q <= '0;
      s_txe_q <= '0;
      s_rxb_q <= '0;
      s_rxg_q <= '0;
      s_rxe_q <= '0;
    end else if (snap_req) begin
      s_txb_q <= txb_q;
      s_txg_q <= txg_q;
      s_txe_q <= txe_q;
      s_rxb_q <= rxb_q;
      s_rxg_q <= rxg_q;
      s_rxe_q <= rxe_q;
    end
  end

  assign snap_tx_bytes = s_txb_q;
  assign snap_tx_good  = s_txg_q;
  assign snap_tx_bad   = s_txe_q;
  assign snap_rx_bytes = s_rxb_q;
  assign snap_rx_good  = s_rxg_q;
  assign snap_rx_bad   = s_rxe_q;
`else
  assign snap_tx_bytes = txb_q;
  assign snap_tx_good  = txg_q;
  assign snap_tx_bad   = txe_q;
  assign snap_rx_bytes = rxb_q;
  assign snap_rx_good  = rxg_q;
  assign snap_rx_bad   = rxe_q;
`endif

endmodule

// File: tb/tb_eth_stats_accumulator.sv
// tb/tb_eth_stats_accumulator.sv - self-checking bench for eth_stats_accumulator (reference model + vectors)
module tb_eth_stats_accumulator;

`ifdef ETH_STATS_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, tx_valid, tx_good, rx_valid, rx_good, snap_req, snap_clear;
  logic [15:0] tx_bytes, rx_bytes;
  logic        snap_done;
  logic [63:0] snap_tx_bytes, snap_tx_good, snap_tx_bad, snap_rx_bytes, snap_rx_good, snap_rx_bad;
  logic [15:0] dropped;

  logic        s_enable, s_tx_valid, s_tx_good, s_rx_valid, s_rx_good, s_snap_req, s_snap_clear;
  logic [15:0] s_tx_bytes, s_rx_bytes;
  logic        s_snap_done;
  logic [17:0] s_snap_tx_bytes, s_snap_tx_good, s_snap_tx_bad, s_snap_rx_bytes, s_snap_rx_good, s_snap_rx_bad;
  logic [15:0] s_dropped;

  eth_stats_accumulator #(.CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .tx_valid(tx_valid), .tx_bytes(tx_bytes), .tx_good(tx_good),
    .rx_valid(rx_valid), .rx_bytes(rx_bytes), .rx_good(rx_good),
    .snap_req(snap_req), .snap_clear(snap_clear), .snap_done(snap_done),
    .snap_tx_bytes(snap_tx_bytes), .snap_tx_good(snap_tx_good), .snap_tx_bad(snap_tx_bad),
    .snap_rx_bytes(snap_rx_bytes), .snap_rx_good(snap_rx_good), .snap_rx_bad(snap_rx_bad),
    .dropped(dropped)
  );

  // Narrow instance so counter wrap-around is reachable in a few reports.
  eth_stats_accumulator #(.CNT_W(18)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .enable(s_enable),
    .tx_valid(s_tx_valid), .tx_bytes(s_tx_bytes), .tx_good(s_tx_good),
    .rx_valid(s_rx_valid), .rx_bytes(s_rx_bytes), .rx_good(s_rx_good),
    .snap_req(s_snap_req), .snap_clear(s_snap_clear), .snap_done(s_snap_done),
    .snap_tx_bytes(s_snap_tx_bytes), .snap_tx_good(s_snap_tx_good), .snap_tx_bad(s_snap_tx_bad),
    .snap_rx_bytes(s_snap_rx_bytes), .snap_rx_good(s_snap_rx_good), .snap_rx_bad(s_snap_rx_bad),
    .dropped(s_dropped)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: counters indexed [src*3 + {0:bytes,1:good,2:bad}], src 0=TX 1=RX.
  longint unsigned m_cnt [6];
  longint unsigned m_snap [6];
  longint unsigned m_len [2];
  bit              m_good [2];
  bit              m_full [2];
  int              m_last;
  longint unsigned m_drop;
  bit              m_done;

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) begin
      m_cnt[i]  = 0;
      m_snap[i] = 0;
    end
    for (int s = 0; s < 2; s++) begin
      m_full[s] = 0;
      m_len[s]  = 0;
      m_good[s] = 0;
    end
    m_last = 1;
    m_drop = 0;
    m_done = 0;
  endfunction

  function automatic void model_step();
    bit              v [2];
    longint unsigned b [2];
    bit              g [2];
    int              gr;
    v[0] = tx_valid; b[0] = longint'(tx_bytes); g[0] = tx_good;
    v[1] = rx_valid; b[1] = longint'(rx_bytes); g[1] = rx_good;
    if (m_full[0] && m_full[1]) gr = 1 - m_last;
    else if (m_full[0])         gr = 0;
    else if (m_full[1])         gr = 1;
    else                        gr = -1;
    m_done = snap_req;
    if (SNAP_EN && snap_req) m_snap = m_cnt;
    if (SNAP_EN && snap_req && snap_clear)
      for (int i = 0; i < 6; i++) m_cnt[i] = 0;
    if (gr >= 0) begin
      m_cnt[3*gr] += m_len[gr];
      m_cnt[3*gr + (m_good[gr] ? 1 : 2)] += 1;
      m_full[gr] = 0;
      m_last = gr;
    end
    for (int s = 0; s < 2; s++) begin
      if (enable && v[s]) begin
        if (m_full[s]) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          m_full[s] = 1;
          m_len[s]  = b[s];
          m_good[s] = g[s];
        end
      end
    end
    if (!SNAP_EN) m_snap = m_cnt;
  endfunction

  task automatic cmp_model();
    logic [63:0] act [6];
    act = '{snap_tx_bytes, snap_tx_good, snap_tx_bad, snap_rx_bytes, snap_rx_good, snap_rx_bad};
    check("model_snap_done", 64'(snap_done), 64'(m_done));
    check("model_dropped", 64'(dropped), m_drop);
    for (int i = 0; i < 6; i++) check($sformatf("model_snap%0d", i), act[i], m_snap[i]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic idle_inputs();
    enable = 1; tx_valid = 0; tx_bytes = 0; tx_good = 0;
    rx_valid = 0; rx_bytes = 0; rx_good = 0; snap_req = 0; snap_clear = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic snap(input bit clr);
    snap_req = 1; snap_clear = clr;
    tick();
    snap_req = 0; snap_clear = 0;
  endtask

  typedef struct {
    bit txv; int txb; bit txg;
    bit rxv; int rxb; bit rxg;
    bit sr;  bit chk;
    longint unsigned e_txb, e_txg, e_rxb, e_rxbad, e_drop;
    bit e_done;
  } vec_t;

  vec_t vt [13];

  initial begin
    longint unsigned base_tx;
    s_enable = 1; s_tx_valid = 0; s_tx_bytes = 0; s_tx_good = 0;
    s_rx_valid = 0; s_rx_bytes = 0; s_rx_good = 0; s_snap_req = 0; s_snap_clear = 0;

    vt[0]  = '{1, 100, 1, 1, 200, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[5]  = '{0, 0, 0, 0, 0, 0, 1, 1, 100, 1, 200, 1, 0, 1};
    vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[7]  = '{1, 10, 1, 1, 20, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[8]  = '{1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[9]  = '{1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[11] = '{0, 0, 0, 0, 0, 0, 1, 1, 121, 3, 220, 1, 1, 1};
    vt[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    do_reset();
    check("reset_snap_done", 64'(snap_done), 0);
    check("reset_dropped", 64'(dropped), 0);
    check("reset_tx_bytes", snap_tx_bytes, 0);
    check("reset_rx_bad", snap_rx_bad, 0);

    // Simultaneous reports then overrun, hand-computed expectations.
    for (int i = 0; i < 13; i++) begin
      tx_valid = vt[i].txv; tx_bytes = 16'(vt[i].txb); tx_good = vt[i].txg;
      rx_valid = vt[i].rxv; rx_bytes = 16'(vt[i].rxb); rx_good = vt[i].rxg;
      snap_req = vt[i].sr;
      tick();
      idle_inputs();
      check($sformatf("vec%0d_snap_done", i), 64'(snap_done), 64'(vt[i].e_done));
      if (vt[i].chk) begin
        check($sformatf("vec%0d_tx_bytes", i), snap_tx_bytes, vt[i].e_txb);
        check($sformatf("vec%0d_tx_good", i), snap_tx_good, vt[i].e_txg);
        check($sformatf("vec%0d_rx_bytes", i), snap_rx_bytes, vt[i].e_rxb);
        check($sformatf("vec%0d_rx_bad", i), snap_rx_bad, vt[i].e_rxbad);
        check($sformatf("vec%0d_dropped", i), 64'(dropped), vt[i].e_drop);
      end
    end

    // Asynchronous reset asserted while an update is granted.
    tx_valid = 1; tx_bytes = 500; tx_good = 1;
    tick();
    idle_inputs();
    #3 rst_n = 0;
    #1;
    check("async_rst_dropped", 64'(dropped), 0);
    check("async_rst_tx_bytes", snap_tx_bytes, 0);
    check("async_rst_tx_good", snap_tx_good, 0);
    check("async_rst_rx_bytes", snap_rx_bytes, 0);
    check("async_rst_rx_bad", snap_rx_bad, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    tx_valid = 1; tx_bytes = 64; tx_good = 1;
    tick();
    idle_inputs();
    tick(); tick();
    snap(0);
    check("single_tx_bytes", snap_tx_bytes, 64);
    check("single_tx_good", snap_tx_good, 1);
    check("single_tx_bad", snap_tx_bad, 0);
    check("single_rx_bytes", snap_rx_bytes, 0);
    check("single_rx_good", snap_rx_good, 0);

    // Both sources saturated at one report every 2 cycles.
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      tx_valid = 1; tx_bytes = 1500; tx_good = 1;
      rx_valid = 1; rx_bytes = 1500; rx_good = 1;
      tick();
      idle_inputs();
      tick();
    end
    repeat (3) tick();
    snap(0);
    check("sat_dropped", 64'(dropped), 0);
    check("sat_tx_bytes", snap_tx_bytes, 64'd1500000);
    check("sat_rx_bytes", snap_rx_bytes, 64'd1500000);

    // Clear collides with a granted RX update.
    do_reset();
    tx_valid = 1; tx_bytes = 64; tx_good = 1;
    tick();
    idle_inputs();
    tick(); tick();
    rx_valid = 1; rx_bytes = 60; rx_good = 1;
    tick();
    idle_inputs();
    snap(1);
    check("clr_first_rx_bytes", snap_rx_bytes, SNAP_EN ? 64'd0 : 64'd60);
    check("clr_first_tx_bytes", snap_tx_bytes, 64'd64);
    tick();
    snap(0);
    check("clr_second_rx_bytes", snap_rx_bytes, 64'd60);
    check("clr_second_tx_bytes", snap_tx_bytes, SNAP_EN ? 64'd0 : 64'd64);

    // Pending report drains after enable drops; disabled reports are ignored.
    base_tx = SNAP_EN ? 64'd0 : 64'd64;
    tx_valid = 1; tx_bytes = 30; tx_good = 1;
    tick();
    enable = 0;
    for (int k = 0; k < 5; k++) begin
      tx_valid = 1; tx_bytes = 999; rx_valid = 1; rx_bytes = 999;
      tick();
    end
    idle_inputs();
    tick();
    snap(0);
    check("en_tx_bytes", snap_tx_bytes, base_tx + 30);
    check("en_rx_bytes", snap_rx_bytes, 64'd60);
    check("en_dropped", 64'(dropped), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      enable     = ($urandom_range(0, 7) != 0);
      tx_valid   = $urandom_range(0, 1) == 1;
      tx_bytes   = 16'($urandom_range(0, 65535));
      tx_good    = $urandom_range(0, 3) != 0;
      rx_valid   = $urandom_range(0, 1) == 1;
      rx_bytes   = 16'($urandom_range(0, 65535));
      rx_good    = $urandom_range(0, 3) != 0;
      snap_req   = $urandom_range(0, 7) == 0;
      snap_clear = $urandom_range(0, 1) == 1;
      tick();
    end
    idle_inputs();

    // Wrap on the narrow instance: 4*65535 + 14 = 2^18 + 10.
    for (int k = 0; k < 5; k++) begin
      s_tx_valid = 1; s_tx_bytes = (k < 4) ? 16'hFFFF : 16'd14; s_tx_good = 1;
      tick();
      s_tx_valid = 0;
      tick(); tick();
    end
    s_snap_req = 1;
    tick();
    s_snap_req = 0;
    check("wrap_tx_bytes", 64'(s_snap_tx_bytes), 64'd10);
    check("wrap_tx_good", 64'(s_snap_tx_good), 64'd5);
    check("wrap_snap_done", 64'(s_snap_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
